// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with valid/ready handshake and multi-cycle mul/div sequencing
module alu_ctrl_seq #(
   parameter int              FUNC_W   = 4,
   parameter int              OP_W     = 3,
   parameter int              CTR_W    = 3,
   parameter logic [OP_W-1:0] RTYPE_OP = OP_W'(4),
   parameter int              MUL_LAT  = 4,
   parameter int              DIV_LAT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FUNC_W-1:0] func,
   input  logic [OP_W-1:0]   aluop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTR_W-1:0]  aluctr,
   output logic              mc,
   output logic              busy
);
   localparam int         MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
   localparam int         CNT_W   = MAX_LAT > 2 ? $clog2(MAX_LAT - 1) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_OUT   = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_multi;
   logic [CTR_W-1:0] w_code;
   logic [CNT_W-1:0] w_lat_m2;

   // Decode the request and decide whether it can be taken this edge
   always_comb begin
      in_ready  = !rst && (r_state == S_IDLE || (r_state == S_OUT && out_ready));
      w_accept  = in_valid && in_ready;
      w_multi   = aluop == RTYPE_OP && func[FUNC_W-1];
      w_code    = aluop == RTYPE_OP ? func[CTR_W-1:0] : CTR_W'(aluop);
      w_lat_m2  = func[0] ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
      out_valid = r_state == S_OUT;
      busy      = r_state == S_WAIT;
   end

   // Sequencer: result registers load at acceptance, WAIT counts down the remaining latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         aluctr  <= '0;
         mc      <= 1'b0;
      end else if (w_accept) begin
         aluctr  <= w_code;
         mc      <= w_multi;
         r_state <= w_multi ? S_WAIT : S_OUT;
         r_cnt   <= w_multi ? w_lat_m2 : '0;
      end else if (r_state == S_WAIT) begin
         if (r_cnt == '0) r_state <= S_OUT;
         else r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_OUT) begin
         if (out_ready) r_state <= S_IDLE;
      end else if (r_state != S_IDLE) begin
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and randomized checks of alu_ctrl_seq against a latency-countdown reference model
module tb_alu_ctrl_seq;
   localparam int         MUL_LAT = 4;
   localparam int         DIV_LAT = 8;
   localparam logic [2:0] RTYPE   = 3'b100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] func = '0;
   logic [2:0] aluop = '0;
   logic       in_ready, out_valid, mc, busy;
   logic [2:0] aluctr;

   int         n_chk = 0;
   int         n_fail = 0;
   int         n_v;
   bit         m_valid = 0;
   int         m_left = 0;
   logic [2:0] m_code = '0;
   bit         m_mc = 0;

   alu_ctrl_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready),
      .aluctr(aluctr), .mc(mc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return !rst && ((m_left == 0 && !m_valid) || (m_valid && out_ready));
   endfunction

   task automatic check_out();
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_left > 0);
      chk("aluctr", aluctr, m_code);
      chk("mc", mc, m_mc);
   endtask

   task automatic step(input bit iv, input logic [3:0] f, input logic [2:0] op, input bit ordy);
      bit acc;
      int lat;
      in_valid = iv; func = f; aluop = op; out_ready = ordy;
      #1;
      chk("in_ready", in_ready, m_ready());
      acc = iv && m_ready();
      if (m_valid && ordy) m_valid = 0;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_valid = 1;
      end
      if (acc) begin
         m_code  = op == RTYPE ? f[2:0] : op;
         m_mc    = op == RTYPE && f[3];
         lat     = m_mc ? (f[0] ? DIV_LAT : MUL_LAT) : 1;
         m_left  = lat - 1;
         m_valid = lat == 1;
      end
      @(posedge clk);
      @(negedge clk);
      check_out();
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      m_valid = 0; m_left = 0; m_code = '0; m_mc = 0;
      chk("rst_in_ready", in_ready, 0);
      check_out();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_out();
      rst = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_in_ready", in_ready, 0);
      check_out();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1, 4'b1111, 3'b010, 1);
      chk("r035", {out_valid, aluctr, mc}, 5'b1_010_0);
      step(1, 4'b0110, RTYPE, 1);
      chk("r036", {out_valid, aluctr, mc}, 5'b1_110_0);
      step(1, 4'b1010, RTYPE, 1);
      chk("r037_busy", {busy, out_valid}, 2'b10);
      repeat (MUL_LAT - 1) step(0, 4'h0, 3'h0, 1);
      chk("r037_mul", {out_valid, aluctr, mc}, 5'b1_010_1);
      step(1, 4'b1011, RTYPE, 1);
      repeat (DIV_LAT - 1) step(0, 4'h0, 3'h0, 1);
      chk("r037_div", {out_valid, aluctr, mc}, 5'b1_011_1);
      repeat (5) step(1, 4'($urandom), 3'($urandom), 0);
      chk("r038_hold", {out_valid, aluctr}, 4'b1_011);
      step(1, 4'h0, 3'b001, 1);
      chk("r038", {out_valid, aluctr, mc}, 5'b1_001_0);
      n_v = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 4'($urandom_range(0, 7)), 3'($urandom), 1);
         n_v += int'(out_valid);
      end
      chk("r040_count", n_v, 10);
      step(1, 4'b1011, RTYPE, 1);
      step(0, 4'h0, 3'h0, 1);
      step(0, 4'h0, 3'h0, 1);
      pulse_reset();
      for (int i = 0; i < 10; i++) step(0, 4'($urandom), 3'($urandom), 1'($urandom));
      chk("r039_quiet", out_valid, 0);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset();
         else step($urandom_range(0, 3) != 0, 4'($urandom),
                   $urandom_range(0, 2) == 0 ? RTYPE : 3'($urandom),
                   $urandom_range(0, 3) != 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
